mul_iter: RTL

- Iterative 32x32 -> 64-bit multiplier for the execute stage: shift-add, one partial product per cycle, signed or unsigned.
- Produces the 64-bit product that the execute stage splits into hi/lo for MULT/MULTU.
- Uses the same start/ready/annul handshake as the divider, so the hazard unit can stall E on `!ready_o` exactly as it does for DIV.

---
 rtl/mul_iter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Start/ready/annul handshake matches the divider so the execute stage can stall on !ready_o.
module mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_mul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  logic [CW-1:0]    counter;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             neg;
  logic [PW-1:0]    resultReg;
  logic             readyReg;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [PW-1:0]    accNext;
  logic [PW-1:0]    accSigned;
  logic             anyZero;

  // Operand magnitudes and the next accumulator value (partial product add plus sign fix)
  always_comb begin
    absA      = (signed_mul_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    absB      = (signed_mul_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    anyZero   = (opdata1_i == '0) || (opdata2_i == '0);
    accNext   = acc + (mplier[0] ? mcand : '0);
    accSigned = neg ? (~accNext + PW'(1)) : accNext;
  end

  // Control FSM and datapath registers; annul overrides everything except reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      resultReg <= '0;
      readyReg  <= 1'b0;
    end else if (annul_i) begin
      state    <= IDLE;
      counter  <= '0;
      readyReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          readyReg <= 1'b0;
          if (start_i) begin
            mcand   <= PW'(absA);
            mplier  <= absB;
            neg     <= signed_mul_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            acc     <= '0;
            counter <= '0;
            if (anyZero) begin
              // Zero operand: product is known, skip the iterations
              state     <= DONE;
              resultReg <= '0;
              readyReg  <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc     <= accNext;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CW'(1);
          if (counter == CW'(WIDTH - 1)) begin
            state     <= DONE;
            counter   <= '0;
            resultReg <= accSigned;
            readyReg  <= 1'b1;
          end
        end
        DONE: begin
          // Start must drop before another operation can be accepted
          if (!start_i) begin
            state    <= IDLE;
            readyReg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          readyReg <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = resultReg;
  assign ready_o  = readyReg;

endmodule
